// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects and FSM states.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'b00,
    HZ_MEM_WAIT = 2'b01,
    HZ_REDIRECT = 2'b10
  } hz_state_t;

  // Redirect hold counter width; covers FLUSH_CYCLES up to 15.
  localparam int RDR_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one EX source register.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the pipeline register fields.
module fwd_sel
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src_rs,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  output logic [1:0]      sel
);

  // A load in EX/MEM has no data yet; the load-use stall covers that case.
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && !mem_memread && (mem_rd != '0) && (mem_rd == src_rs)) begin
      sel = FWD_EXMEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src_rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forward control for the 5-stage pipeline; HAZARD_PERF_EN adds perf counters.
// Latency: stall/flush/fwd are combinational from inputs and state; mem_err sets in the threshold cycle.
// Backpressure: a pending data-memory access freezes PC..EX/MEM and bubbles MEM/WB until ready.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic            mem_memread,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic            ex_redirect,
  input  logic            dmem_req,
  input  logic            dmem_ready,
  output logic            pc_stall,
  output logic            if_id_stall,
  output logic            if_id_flush,
  output logic            id_ex_stall,
  output logic            id_ex_flush,
  output logic            ex_mem_stall,
  output logic            mem_wb_bubble,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            mem_err,
  output logic [1:0]      hz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_lu_cnt
`endif
);

  localparam logic [RDR_W-1:0] RDR_RELOAD  = RDR_W'(FLUSH_CYCLES - 1);
  localparam bit               MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam bit               TO_EN       = (MEM_TIMEOUT > 0);
  localparam int               TO_LIM      = TO_EN ? MEM_TIMEOUT - 1 : 0;
  localparam int               TO_W        = (TO_LIM > 0) ? $clog2(TO_LIM + 1) : 1;

  hz_state_t        state_q, state_d;
  logic [RDR_W-1:0] rdr_cnt_q, rdr_cnt_d;
  logic [TO_W-1:0]  to_cnt_q;
  logic             mem_err_q;
  logic             memstall, lu_hit, lu_now, redirect_now, flush_hold, to_hit;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign memstall     = dmem_req & ~dmem_ready;
  assign lu_hit       = ex_memread & ex_regwrite & (ex_rd != '0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign redirect_now = ex_redirect & ~memstall;
  assign lu_now       = lu_hit & ~memstall & ~ex_redirect;
  // A redirect interrupted by a memory wait keeps its remaining count.
  assign flush_hold   = (rdr_cnt_q != '0) & ~memstall;
  assign to_hit       = TO_EN & memstall & (to_cnt_q == TO_W'(TO_LIM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = HZ_RUN;
    rdr_cnt_d = rdr_cnt_q;
    if (memstall) begin
      state_d = HZ_MEM_WAIT;
    end else if (redirect_now) begin
      state_d   = MULTI_FLUSH ? HZ_REDIRECT : HZ_RUN;
      rdr_cnt_d = RDR_RELOAD;
    end else if (rdr_cnt_q != '0) begin
      state_d   = (rdr_cnt_q > RDR_W'(1)) ? HZ_REDIRECT : HZ_RUN;
      rdr_cnt_d = rdr_cnt_q - 1'b1;
    end
  end

  // Outputs are forced quiet while reset is held so the pipeline sees no stray stall.
  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      if (memstall) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else begin
        pc_stall    = lu_now;
        if_id_stall = lu_now;
        if_id_flush = redirect_now | flush_hold;
        id_ex_flush = redirect_now | lu_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdr_cnt_q <= '0;
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      rdr_cnt_q <= rdr_cnt_d;
      mem_err_q <= mem_err_q | to_hit;
      if (!memstall) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q != TO_W'(TO_LIM)) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .src_rs       (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (fwd_a_raw)
  );

  fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .src_rs       (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .mem_memread  (mem_memread),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .sel          (fwd_b_raw)
  );

  assign fwd_a    = rst ? fwd_a_raw : FWD_RF;
  assign fwd_b    = rst ? fwd_b_raw : FWD_RF;
  assign mem_err  = rst & (mem_err_q | to_hit);
  assign hz_state = state_q;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_lu_cnt    <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(memstall);
      perf_flush_cnt <= perf_flush_cnt + CNT_W'(redirect_now);
      perf_lu_cnt    <= perf_lu_cnt + CNT_W'(lu_now);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=4; expectations queued then checked.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_MS   = 7'b1101011;
  localparam logic [6:0] C_RD   = 7'b0010100;
  localparam logic [6:0] C_IFF  = 7'b0010000;
  localparam logic [1:0] S_RUN  = 2'b00;
  localparam logic [1:0] S_MW   = 2'b01;
  localparam logic [1:0] S_RD   = 2'b10;
  localparam logic [1:0] F_RF   = 2'b00;
  localparam logic [1:0] F_EM   = 2'b01;
  localparam logic [1:0] F_WB   = 2'b10;

  typedef struct {
    string       tag;
    logic [13:0] v;
  } exp_t;

  logic       clk, rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite, mem_memread;
  logic       wb_regwrite, ex_redirect, dmem_req, dmem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic       mem_wb_bubble, mem_err;
  logic [1:0] fwd_a, fwd_b, hz_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_lu_cnt;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  pipe_hazard_ctrl #(.RA_W(5), .FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .hz_state(hz_state)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt), .perf_lu_cnt(perf_lu_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] ev(input logic [6:0] c, input logic [1:0] fa, input logic [1:0] fb,
                                     input logic err, input logic [1:0] st);
    return {c, fa, fb, err, st};
  endfunction

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0;
    wb_rd = '0; wb_regwrite = 1'b0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = rd;
    id_rs1 = rs1; id_use_rs1 = 1'b1; id_rs2 = rs2; id_use_rs2 = 1'b1;
  endtask

  task automatic check_out();
    exp_t        x;
    logic [13:0] obs;
    x   = exp_q.pop_front();
    obs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
           mem_wb_bubble, fwd_a, fwd_b, mem_err, hz_state};
    vectors++;
    assert (obs === x.v) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
    end
  endtask

  // Queue the expectation, sample mid-cycle, then advance to just after the next edge.
  task automatic step(input string tag, input logic [13:0] e);
    exp_q.push_back('{tag, e});
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_PERF_EN
  task automatic check_perf_zero(input string tag);
    vectors++;
    assert ({perf_stall_cnt, perf_flush_cnt, perf_lu_cnt} === 96'd0) else begin
      miscompares++;
      $error("FAIL %s: observed %0d/%0d/%0d expected 0/0/0", tag,
             perf_stall_cnt, perf_flush_cnt, perf_lu_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    idle();
    dmem_req = 1'b1; ex_redirect = 1'b1; mem_rd = 5'd3; mem_regwrite = 1'b1; ex_rs1 = 5'd3;
    step("reset", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));
    idle(); rst = 1'b1;

    load_use(5'd5, 5'd5, 5'd1);
    step("lu_rs1", ev(C_LU, F_RF, F_RF, 1'b0, S_RUN));
    idle(); mem_rd = 5'd5; mem_regwrite = 1'b1; mem_memread = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    step("lu_after", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));
    idle(); load_use(5'd9, 5'd2, 5'd9);
    step("lu_rs2", ev(C_LU, F_RF, F_RF, 1'b0, S_RUN));
    id_use_rs2 = 1'b0;
    step("lu_nouse", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));
    idle(); load_use(5'd0, 5'd0, 5'd0);
    step("lu_x0", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));

    idle(); mem_rd = 5'd7; mem_regwrite = 1'b1; wb_rd = 5'd7; wb_regwrite = 1'b1;
    ex_rs1 = 5'd7; ex_rs2 = 5'd3;
    step("fwd_exmem", ev(C_NONE, F_EM, F_RF, 1'b0, S_RUN));
    mem_memread = 1'b1;
    step("fwd_ld_skip", ev(C_NONE, F_WB, F_RF, 1'b0, S_RUN));
    mem_memread = 1'b0; mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    step("fwd_x0", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));
    ex_rs2 = 5'd4; wb_rd = 5'd4; mem_rd = 5'd4; mem_regwrite = 1'b0;
    step("fwd_wb_b", ev(C_NONE, F_RF, F_WB, 1'b0, S_RUN));
    mem_regwrite = 1'b1;
    step("fwd_b_prio", ev(C_NONE, F_RF, F_EM, 1'b0, S_RUN));

    idle(); dmem_req = 1'b1; load_use(5'd5, 5'd5, 5'd0);
    step("ms1", ev(C_MS, F_RF, F_RF, 1'b0, S_RUN));
    idle(); dmem_req = 1'b1;
    step("ms2", ev(C_MS, F_RF, F_RF, 1'b0, S_MW));
    step("ms3", ev(C_MS, F_RF, F_RF, 1'b0, S_MW));
    dmem_ready = 1'b1;
    step("ms_ready", ev(C_NONE, F_RF, F_RF, 1'b0, S_MW));
    idle();
    step("ms_run", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));

    ex_redirect = 1'b1;
    step("rd0", ev(C_RD, F_RF, F_RF, 1'b0, S_RUN));
    idle();
    step("rd1", ev(C_IFF, F_RF, F_RF, 1'b0, S_RD));
    step("rd2", ev(C_IFF, F_RF, F_RF, 1'b0, S_RD));
    step("rd_done", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));

    load_use(5'd5, 5'd5, 5'd0); ex_redirect = 1'b1;
    step("rd_lu", ev(C_RD, F_RF, F_RF, 1'b0, S_RUN));
    idle();
    step("rdlu1", ev(C_IFF, F_RF, F_RF, 1'b0, S_RD));
    ex_redirect = 1'b1;
    step("rd_restart", ev(C_RD, F_RF, F_RF, 1'b0, S_RD));
    idle();
    step("rs1", ev(C_IFF, F_RF, F_RF, 1'b0, S_RD));
    step("rs2", ev(C_IFF, F_RF, F_RF, 1'b0, S_RD));
    step("rs_done", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));

    ex_redirect = 1'b1;
    step("rdm0", ev(C_RD, F_RF, F_RF, 1'b0, S_RUN));
    idle();
    step("rdm1", ev(C_IFF, F_RF, F_RF, 1'b0, S_RD));
    dmem_req = 1'b1;
    step("rdm_stall", ev(C_MS, F_RF, F_RF, 1'b0, S_RD));
    dmem_ready = 1'b1;
    step("rdm_resume", ev(C_IFF, F_RF, F_RF, 1'b0, S_MW));
    idle();
    step("rdm_done", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));

    dmem_req = 1'b1; ex_redirect = 1'b1;
    step("hold_ms", ev(C_MS, F_RF, F_RF, 1'b0, S_RUN));
    dmem_ready = 1'b1;
    step("hold_go", ev(C_RD, F_RF, F_RF, 1'b0, S_MW));
    idle();
    step("hold_f1", ev(C_IFF, F_RF, F_RF, 1'b0, S_RD));
    step("hold_f2", ev(C_IFF, F_RF, F_RF, 1'b0, S_RD));
    step("hold_done", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));

    dmem_req = 1'b1;
    step("to1", ev(C_MS, F_RF, F_RF, 1'b0, S_RUN));
    step("to2", ev(C_MS, F_RF, F_RF, 1'b0, S_MW));
    step("to3", ev(C_MS, F_RF, F_RF, 1'b0, S_MW));
    step("to4", ev(C_MS, F_RF, F_RF, 1'b1, S_MW));
    step("to5", ev(C_MS, F_RF, F_RF, 1'b1, S_MW));
    step("to6", ev(C_MS, F_RF, F_RF, 1'b1, S_MW));
    dmem_ready = 1'b1;
    step("to_ready", ev(C_NONE, F_RF, F_RF, 1'b1, S_MW));
    idle();
    step("to_sticky", ev(C_NONE, F_RF, F_RF, 1'b1, S_RUN));

    ex_redirect = 1'b1;
    step("r6_rd", ev(C_RD, F_RF, F_RF, 1'b1, S_RUN));
    idle();
    step("r6_rd2", ev(C_IFF, F_RF, F_RF, 1'b1, S_RD));
    rst = 1'b0;
    step("rst_redirect", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));
    rst = 1'b1;
    step("post_rst1", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));

    dmem_req = 1'b1;
    step("m6a", ev(C_MS, F_RF, F_RF, 1'b0, S_RUN));
    step("m6b", ev(C_MS, F_RF, F_RF, 1'b0, S_MW));
    rst = 1'b0;
    step("rst_memwait", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));
`ifdef HAZARD_PERF_EN
    check_perf_zero("perf_rst");
`endif
    idle(); rst = 1'b1;
    step("post_rst2", ev(C_NONE, F_RF, F_RF, 1'b0, S_RUN));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
